// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Single-port, zero-latency SRAM responder model with access counters and a
// bench back-door read port. Reads are combinational (Q follows mem[A] in the
// same cycle), writes land at the rising clock edge. Every storage word and
// both counters are cleared asynchronously by rst_n.
//
// Ports
//   clk       in   1    clock, all state updates on the rising edge
//   rst_n     in   1    asynchronous active-low reset
//   CEN       in   1    chip enable, active-low (1 = no access this cycle)
//   WEN       in   1    0 = write, 1 = read; only meaningful when CEN = 0
//   OEN       in   1    output enable, active-low; gates Q only
//   A         in   AW   word address
//   D         in   DW   write data
//   Q         out  DW   read data, 0 unless a read is enabled and driven
//   dbg_addr  in   AW   back-door word address
//   dbg_data  out  DW   mem[dbg_addr], independent of CEN/OEN
//   rd_cnt    out  16   saturating count of read accesses since reset
//   wr_cnt    out  16   saturating count of write accesses since reset
// -----------------------------------------------------------------------------
module data_sram_responder #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          CEN,
   input  logic          WEN,
   input  logic          OEN,
   input  logic [AW-1:0] A,
   input  logic [DW-1:0] D,
   output logic [DW-1:0] Q,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic [15:0]   rd_cnt,
   output logic [15:0]   wr_cnt
);

   typedef enum logic [1:0] {
      ACC_IDLE  = 2'd0,
      ACC_READ  = 2'd1,
      ACC_WRITE = 2'd2
   } acc_t;

   logic [DW-1:0] r_mem [DEPTH];
   logic [15:0]   r_rd_cnt;
   logic [15:0]   r_wr_cnt;
   acc_t          w_acc;
   logic [DW-1:0] w_q;
   logic [DW-1:0] w_dbg;

   // Access type is decoded fresh every cycle from the pins, so any mix of
   // reads and writes can run back to back with no turnaround cycle.
   always_comb begin
      w_acc = ACC_IDLE;
      if (!CEN) begin
         if (WEN) w_acc = ACC_READ;
         else     w_acc = ACC_WRITE;
      end
   end

   // Storage. The async clear also guarantees a write whose edge falls inside
   // a reset pulse is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_acc == ACC_WRITE) begin
         r_mem[A] <= D;
      end
   end

   // Counters hold at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_acc == ACC_READ && r_rd_cnt != 16'hFFFF)
            r_rd_cnt <= r_rd_cnt + 16'd1;
         if (w_acc == ACC_WRITE && r_wr_cnt != 16'hFFFF)
            r_wr_cnt <= r_wr_cnt + 16'd1;
      end
   end

   // Q is forced to 0 outside an output-enabled read rather than floated, so
   // the initiator never samples X or Z.
   always_comb begin
      w_q = '0;
      if (rst_n && w_acc == ACC_READ && !OEN) w_q = r_mem[A];
   end

   always_comb begin
      w_dbg = '0;
      if (rst_n) w_dbg = r_mem[dbg_addr];
   end

   assign Q        = w_q;
   assign dbg_data = w_dbg;
   assign rd_cnt   = r_rd_cnt;
   assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_data_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_data_sram_responder
//
// Self-checking bench for data_sram_responder. A behavioural model (word array
// plus two saturating counters) is updated from the access rules at each
// rising edge; DUT outputs are sampled 1-2 time units after the edge.
// -----------------------------------------------------------------------------
module tb_data_sram_responder;

   localparam int DEPTH = 128;
   localparam int AW    = 7;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          CEN, WEN, OEN;
   logic [AW-1:0] A;
   logic [DW-1:0] D;
   logic [DW-1:0] Q;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;
   logic [15:0]   rd_cnt, wr_cnt;

   // reference model
   logic [DW-1:0] mem_m [DEPTH];
   logic [15:0]   rd_m, wr_m;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   data_sram_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .CEN      (CEN),
      .WEN      (WEN),
      .OEN      (OEN),
      .A        (A),
      .D        (D),
      .Q        (Q),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt)
   );

   function automatic logic [DW-1:0] exp_q();
      if (rst_n && !CEN && WEN && !OEN) return mem_m[A];
      return '0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      rd_m = '0;
      wr_m = '0;
   endtask

   // Apply pins and let combinational outputs settle.
   task automatic drive(input logic cen, input logic wen, input logic oen,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      CEN = cen; WEN = wen; OEN = oen; A = a; D = d;
      #1;
   endtask

   // Advance one rising edge, updating the model from the pins in force.
   task automatic tick();
      @(posedge clk);
      if (rst_n && !CEN) begin
         if (WEN) begin
            if (rd_m != 16'hFFFF) rd_m = rd_m + 16'd1;
         end else begin
            mem_m[A] = D;
            if (wr_m != 16'hFFFF) wr_m = wr_m + 16'd1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      dbg_addr = 7'h05;
      drive(1'b1, 1'b1, 1'b1, 7'h00, 32'h0);
      rst_n = 1'b0;
      model_clear();
      drive(1'b0, 1'b0, 1'b0, 7'h05, 32'hFFFF_FFFF);
      n_cmp++;
      if (Q !== 32'h0) begin n_err++; $display("FAIL reset_q: got %h want %h", Q, 32'h0); end
      tick();
      tick();
      drive(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
      n_cmp++;
      if (Q !== 32'h0) begin n_err++; $display("FAIL reset_q_read: got %h want %h", Q, 32'h0); end
      n_cmp++;
      if (dbg_data !== 32'h0) begin n_err++; $display("FAIL reset_dbg: got %h want %h", dbg_data, 32'h0); end
      n_cmp++;
      if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
         n_err++; $display("FAIL reset_cnt: got rd=%h wr=%h want 0/0", rd_cnt, wr_cnt);
      end
      drive(1'b1, 1'b1, 1'b1, 7'h00, 32'h0);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (dbg_data !== 32'h0) begin n_err++; $display("FAIL reset_no_write: got %h want %h", dbg_data, 32'h0); end
   endtask

   task automatic test_first_read();
      drive(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
      n_cmp++;
      if (Q !== 32'h0) begin n_err++; $display("FAIL first_read_q: got %h want %h", Q, 32'h0); end
      tick();
      n_cmp++;
      if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
         n_err++; $display("FAIL first_read_cnt: got rd=%h wr=%h want 1/0", rd_cnt, wr_cnt);
      end
   endtask

   task automatic test_write_read();
      drive(1'b0, 1'b0, 1'b1, 7'h10, 32'hDEADBEEF);
      tick();
      drive(1'b0, 1'b1, 1'b0, 7'h10, 32'h0);
      n_cmp++;
      if (Q !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_q: got %h want %h", Q, 32'hDEADBEEF); end
      dbg_addr = 7'h10; #1;
      n_cmp++;
      if (dbg_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_dbg10: got %h want %h", dbg_data, 32'hDEADBEEF); end
      dbg_addr = 7'h11; #1;
      n_cmp++;
      if (dbg_data !== 32'h0) begin n_err++; $display("FAIL wr_rd_dbg11: got %h want %h", dbg_data, 32'h0); end
      tick();
      n_cmp++;
      if (rd_cnt !== rd_m || wr_cnt !== wr_m) begin
         n_err++; $display("FAIL wr_rd_cnt: got rd=%h wr=%h want %h/%h", rd_cnt, wr_cnt, rd_m, wr_m);
      end
   endtask

   task automatic test_oen_gate();
      logic [15:0] rd0;
      rd0 = rd_cnt;
      drive(1'b0, 1'b1, 1'b1, 7'h10, 32'h0);
      n_cmp++;
      if (Q !== 32'h0) begin n_err++; $display("FAIL oen_q: got %h want %h", Q, 32'h0); end
      tick();
      n_cmp++;
      if (rd_cnt !== rd0 + 16'd1) begin n_err++; $display("FAIL oen_rdcnt: got %h want %h", rd_cnt, rd0 + 16'd1); end
   endtask

   task automatic test_idle();
      logic [15:0] rd0, wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      drive(1'b1, 1'b0, 1'b0, 7'h10, 32'h12345678);
      n_cmp++;
      if (Q !== 32'h0) begin n_err++; $display("FAIL idle_q: got %h want %h", Q, 32'h0); end
      tick();
      dbg_addr = 7'h10; #1;
      n_cmp++;
      if (dbg_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_mem: got %h want %h", dbg_data, 32'hDEADBEEF); end
      n_cmp++;
      if (rd_cnt !== rd0 || wr_cnt !== wr0) begin
         n_err++; $display("FAIL idle_cnt: got rd=%h wr=%h want %h/%h", rd_cnt, wr_cnt, rd0, wr0);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0]   rd0, wr0;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      rd0 = rd_cnt; wr0 = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         addr = (i % 2 == 0) ? 7'h7F : 7'h00;
         wd   = $urandom;
         drive(1'b0, 1'b0, 1'b0, addr, wd);
         tick();
         drive(1'b0, 1'b1, 1'b0, addr, $urandom);
         n_cmp++;
         if (Q !== wd) begin n_err++; $display("FAIL b2b_q[%0d]: got %h want %h", i, Q, wd); end
         tick();
      end
      n_cmp++;
      if (rd_cnt !== rd0 + 16'd4 || wr_cnt !== wr0 + 16'd4) begin
         n_err++; $display("FAIL b2b_cnt: got rd=%h wr=%h want %h/%h", rd_cnt, wr_cnt, rd0 + 16'd4, wr0 + 16'd4);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] da;
      for (int i = 0; i < 300; i++) begin
         // narrow address range so reads often hit previously written words
         drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
               AW'($urandom_range(0, 15)), $urandom);
         da = AW'($urandom_range(0, 15));
         dbg_addr = da; #1;
         n_cmp++;
         if (Q !== exp_q()) begin n_err++; $display("FAIL rand_q[%0d]: got %h want %h", i, Q, exp_q()); end
         n_cmp++;
         if (dbg_data !== mem_m[da]) begin n_err++; $display("FAIL rand_dbg[%0d]: got %h want %h", i, dbg_data, mem_m[da]); end
         tick();
         n_cmp++;
         if (rd_cnt !== rd_m || wr_cnt !== wr_m) begin
            n_err++; $display("FAIL rand_cnt[%0d]: got rd=%h wr=%h want %h/%h", i, rd_cnt, wr_cnt, rd_m, wr_m);
         end
      end
   endtask

   task automatic test_saturation_and_reset();
      logic [15:0] rd0;
      rd0 = rd_cnt;
      for (int i = 0; i < 65540; i++) begin
         drive(1'b0, 1'b0, 1'b0, AW'($urandom), $urandom);
         tick();
      end
      n_cmp++;
      if (wr_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_wr: got %h want %h", wr_cnt, 16'hFFFF); end
      n_cmp++;
      if (rd_cnt !== rd0) begin n_err++; $display("FAIL sat_rd_hold: got %h want %h", rd_cnt, rd0); end
      drive(1'b0, 1'b0, 1'b0, 7'h22, 32'h0BADF00D);
      tick();
      n_cmp++;
      if (wr_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_stay: got %h want %h", wr_cnt, 16'hFFFF); end
      dbg_addr = 7'h22; #1;
      n_cmp++;
      if (dbg_data !== 32'h0BADF00D) begin n_err++; $display("FAIL sat_write_lands: got %h want %h", dbg_data, 32'h0BADF00D); end
      // reset arrives mid-cycle while a write is set up
      dbg_addr = 7'h33;
      drive(1'b0, 1'b0, 1'b0, 7'h33, 32'hA5A5A5A5);
      rst_n = 1'b0;
      model_clear();
      #1;
      n_cmp++;
      if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
         n_err++; $display("FAIL midrst_cnt: got rd=%h wr=%h want 0/0", rd_cnt, wr_cnt);
      end
      tick();
      n_cmp++;
      if (dbg_data !== 32'h0) begin n_err++; $display("FAIL midrst_dbg: got %h want %h", dbg_data, 32'h0); end
      drive(1'b1, 1'b1, 1'b1, 7'h00, 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 7'h33, 32'h0);
      n_cmp++;
      if (Q !== 32'h0) begin n_err++; $display("FAIL midrst_target: got %h want %h", Q, 32'h0); end
      n_cmp++;
      if (dbg_data !== 32'h0) begin n_err++; $display("FAIL midrst_dbg_after: got %h want %h", dbg_data, 32'h0); end
      // first access after release is honoured on the first edge
      drive(1'b0, 1'b0, 1'b0, 7'h33, 32'h5A5A5A5A);
      tick();
      n_cmp++;
      if (dbg_data !== mem_m[7'h33] || wr_cnt !== 16'd1 || rd_cnt !== 16'd0) begin
         n_err++; $display("FAIL post_rst_write: got d=%h rd=%h wr=%h want d=%h rd=0 wr=1",
                           dbg_data, rd_cnt, wr_cnt, mem_m[7'h33]);
      end
   endtask

   initial begin
      test_reset();
      test_first_read();
      test_write_read();
      test_oen_gate();
      test_idle();
      test_back_to_back();
      test_random();
      test_saturation_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit words stored.
REQ-002 SHALL have parameter AW, default 7, word-address width (2^AW = DEPTH).
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port CEN  input  1  chip enable, active-low; 1 = no access this cycle.
REQ-007 SHALL have port WEN  input  1  write enable, 0 = write, 1 = read; qualified by CEN=0.
REQ-008 SHALL have port OEN  input  1  output enable, active-low; gates Q only.
REQ-009 SHALL have port A  input  AW  word address, i.e. initiator byte address bits [8:2].
REQ-010 SHALL have port D  input  DW  write data.
REQ-011 SHALL have port Q  output  DW  read data to initiator.
REQ-012 SHALL have port dbg_addr  input  AW  bench back-door word address.
REQ-013 SHALL have port dbg_data  output  DW  back-door read data, combinational, unconditioned by CEN/OEN.
REQ-014 SHALL have port rd_cnt  output  16  count of read accesses since reset.
REQ-015 SHALL have port wr_cnt  output  16  count of write accesses since reset.

Function
REQ-016 SHALL contain storage of DEPTH words x DW bits, mem[0..DEPTH-1].
REQ-017 Read access (cycle with CEN=0, WEN=1) SHALL be zero-latency: Q = mem[A] combinationally in the same cycle, so a single-cycle initiator can capture it at the next edge.
REQ-018 Q SHALL be 0 whenever OEN=1, CEN=1, or WEN=0; no tri-state, no X.
REQ-019 Write access (cycle with CEN=0, WEN=0, sampled at rising clk) SHALL store D into mem[A] at that edge; OEN value SHALL NOT affect writes.
REQ-020 Same-cycle read-during-write to one address is not possible (WEN selects one); a read in cycle N+1 of an address written at end of cycle N SHALL return the new data.
REQ-021 A presented during a write cycle SHALL be the only word modified; all other words unchanged.
REQ-022 CEN=1 SHALL make WEN, A, D don't-care: no storage change, no counter change.
REQ-023 rd_cnt SHALL increment by 1 at each rising edge where CEN=0 and WEN=1, regardless of OEN.
REQ-024 wr_cnt SHALL increment by 1 at each rising edge where CEN=0 and WEN=0.
REQ-025 Both counters SHALL saturate at 16'hFFFF (no wrap-around).
REQ-026 Address arithmetic SHALL be unsigned AW-bit; A values are always in range (DEPTH = 2^AW), no out-of-range case exists.
REQ-027 dbg_data SHALL equal mem[dbg_addr] at all times, reflecting a write one edge after it lands.
REQ-028 Access state machine: IDLE (CEN=1), READ (CEN=0,WEN=1), WRITE (CEN=0,WEN=0), decoded per cycle from inputs; back-to-back accesses of any mix SHALL be supported every cycle with no dead cycles.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear every mem word to 0, rd_cnt to 0, wr_cnt to 0.
REQ-030 While rst_n=0, Q and dbg_data SHALL read 0 and no write or count SHALL occur even if CEN=0.
REQ-031 Reset asserted mid-write (during the cycle before the edge) SHALL discard that write; first access after rst_n rises is honoured at the first rising edge with rst_n=1.

Verification
REQ-032 Reset then read A=7'h05, OEN=0 -> Q=32'h0, rd_cnt=1 after the edge, wr_cnt=0.
REQ-033 Write A=7'h10, D=32'hDEADBEEF, then read A=7'h10 next cycle -> Q=32'hDEADBEEF same cycle, dbg_data at dbg_addr=7'h10 = 32'hDEADBEEF, mem[7'h11]=0.
REQ-034 Read A=7'h10 with OEN=1 -> Q=32'h0, rd_cnt still increments.
REQ-035 CEN=1, WEN=0, A=7'h10, D=32'h12345678 -> mem[7'h10] unchanged (32'hDEADBEEF), counters unchanged.
REQ-036 Alternate write/read every cycle to A=7'h7F and 7'h00 for 8 cycles -> every read returns the value written the cycle before; wr_cnt=4, rd_cnt=4.
REQ-037 Force wr_cnt to saturation via 65540 writes -> wr_cnt=16'hFFFF, stays; then assert rst_n=0 mid-write of D=32'hA5A5A5A5 -> target word reads 0, both counters 0.
